// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
//   Bus between the UART RX controller and the rest of the receive path:
//   the serial line and static configuration, the registered results of
//   the sampler and checkers, and the enables and frame status that the
//   controller drives.
//
//   master : the controller (uart_rx_ctrl)
//   slave  : the surrounding receive path (sampler, checkers, deserializer)
//
//   Signals
//     rx_in        serial line, idles high
//     prescale     oversampling ratio (8, 16 or 32)
//     par_en       parity bit present in the frame
//     sampled_bit  majority-voted bit from the sampler
//     strt_glitch  start-checker result, registered
//     par_err      parity-checker result, registered
//     stop_err     stop-checker result, registered
//     edge_cnt     oversample edge index within the current bit
//     bit_cnt      bit index within the frame
//     dat_samp_en  sampler enable
//     strt_chk_en  start-check enable (single cycle)
//     par_chk_en   parity-check enable (single cycle)
//     stop_chk_en  stop-check enable (single cycle)
//     deser_en     deserializer shift strobe (single cycle)
//     data_valid   one-cycle pulse per good frame
//     frame_err    one-cycle pulse per bad frame (stop or parity error)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if #(
   parameter int PRESCALE_W = 6
);
   logic                  rx_in;
   logic [PRESCALE_W-1:0] prescale;
   logic                  par_en;
   logic                  sampled_bit;
   logic                  strt_glitch;
   logic                  par_err;
   logic                  stop_err;

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  dat_samp_en;
   logic                  strt_chk_en;
   logic                  par_chk_en;
   logic                  stop_chk_en;
   logic                  deser_en;
   logic                  data_valid;
   logic                  frame_err;

   modport master (
      input  rx_in, prescale, par_en, sampled_bit, strt_glitch, par_err, stop_err,
      output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stop_chk_en,
             deser_en, data_valid, frame_err
   );

   modport slave (
      output rx_in, prescale, par_en, sampled_bit, strt_glitch, par_err, stop_err,
      input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en, stop_chk_en,
             deser_en, data_valid, frame_err
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-path controller for the UART RX. Detects the start edge on
//   rx_in, counts oversampling edges and bit positions, and issues
//   single-cycle enables to the sampler, start/parity/stop checkers and
//   deserializer. It collects the registered check results and emits one
//   data_valid or frame_err pulse per frame.
//
//   Optional feature: define UART_RX_PARITY_EN to include the PARITY state,
//   the parity error flag and par_chk_en. Without it, frames have no parity
//   bit, par_chk_en is tied low, and par_en/par_err are ignored.
//
//   Ports
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    uart_rx_ctrl_if.master (line, config, check results in;
//            counters, enables and frame status out)
//
//   Parameters
//     PRESCALE_W  width of prescale / edge_cnt
//     DATA_W      data bits per frame (LSB first)
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int PRESCALE_W = 6,
   parameter int DATA_W     = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_ctrl_if.master bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

   logic [2:0]            state, state_nxt;
   logic [PRESCALE_W-1:0] edge_cnt, edge_cnt_nxt;
   logic [3:0]            bit_cnt, bit_cnt_nxt;

   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] samp_pt;
   logic [PRESCALE_W-1:0] eval_pt;
   logic [PRESCALE_W-1:0] last_edge;
   logic                  at_samp;
   logic                  at_eval;
   logic                  at_last;
   logic                  stop_eval;
   logic                  par_flag;
   logic                  unused_in;

   // The sampler votes on mid-1, mid, mid+1, so its result (and the point
   // where checkers are enabled) is mid+2; registered check results are
   // available one cycle later at mid+3.
   assign mid       = bus.prescale >> 1;
   assign samp_pt   = mid + PRESCALE_W'(2);
   assign eval_pt   = mid + PRESCALE_W'(3);
   assign last_edge = bus.prescale - PRESCALE_W'(1);

   assign at_samp = (edge_cnt == samp_pt);
   assign at_eval = (edge_cnt == eval_pt);
   assign at_last = (edge_cnt == last_edge);

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      edge_cnt_nxt = at_last ? '0 : edge_cnt + PRESCALE_W'(1);
      case (state)
         S_IDLE: begin
            edge_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            if (!bus.rx_in) state_nxt = S_START;
         end
         S_START: begin
            // Glitch abort wins over the end-of-bit transition; with
            // prescale 8 both fall on the same edge.
            if (at_eval && bus.strt_glitch) begin
               state_nxt    = S_IDLE;
               edge_cnt_nxt = '0;
            end else if (at_last) begin
               state_nxt   = S_DATA;
               bit_cnt_nxt = '0;
            end
         end
         S_DATA: begin
            if (at_last) begin
               bit_cnt_nxt = bit_cnt + 4'd1;
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = bus.par_en ? S_PARITY : S_STOP;
`else
                  state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (at_last) begin
               bit_cnt_nxt = bit_cnt + 4'd1;
               state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Leave at mid-bit so a start edge right after the stop bit
            // is seen from IDLE.
            if (at_eval) begin
               state_nxt    = S_IDLE;
               edge_cnt_nxt = '0;
               bit_cnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt    = S_IDLE;
            edge_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         edge_cnt <= edge_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
      end
   end

   assign stop_eval = (state == S_STOP) && at_eval;

`ifdef UART_RX_PARITY_EN
   // Parity result is held until the stop bit is evaluated, then cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_flag <= 1'b0;
      end else if (stop_eval) begin
         par_flag <= 1'b0;
      end else if ((state == S_PARITY) && at_eval) begin
         par_flag <= bus.par_err;
      end
   end

   assign bus.par_chk_en = (state == S_PARITY) && at_samp;
   assign unused_in      = &{1'b0, bus.sampled_bit};
`else
   assign par_flag       = 1'b0;
   assign bus.par_chk_en = 1'b0;
   assign unused_in      = &{1'b0, bus.sampled_bit, bus.par_en, bus.par_err};
`endif

   // sampled_bit travels on the bus to the deserializer; this block never
   // needs the bit value itself.

   assign bus.edge_cnt    = edge_cnt;
   assign bus.bit_cnt     = bit_cnt;
   assign bus.dat_samp_en = (state != S_IDLE);
   assign bus.strt_chk_en = (state == S_START) && at_samp;
   assign bus.deser_en    = (state == S_DATA) && at_samp;
   assign bus.stop_chk_en = (state == S_STOP) && at_samp;
   assign bus.data_valid  = stop_eval && !bus.stop_err && !par_flag;
   assign bus.frame_err   = stop_eval && (bus.stop_err || par_flag);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl. Drives a serial line, a delayed-line
//   stand-in for the sampler, and registered checker results that answer
//   the controller's enables; counts the controller's pulses per frame and
//   compares them with hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   logic clk;
   logic rst_n;

   uart_rx_ctrl_if #(.PRESCALE_W(6)) bus ();

   uart_rx_ctrl #(.PRESCALE_W(6), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int fails;

   int cyc;
   int n_deser, n_par, n_strt, n_stop, n_dv, n_fe, n_start;
   int dv_cyc, fe_cyc, fall_cyc, low_cyc;
   int starts[4];
   int start_edges[4];
   logic [7:0]  word;
   logic [15:0] deser_mask;
   logic        samp_prev;
   logic        rx_p1, rx_p2;
   logic        glitch_cfg, par_cfg, stop_cfg, par_force;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.strt_chk_en,
                   bus.par_chk_en, bus.stop_chk_en, bus.deser_en,
                   bus.data_valid, bus.frame_err});
   endfunction

   task automatic clear_stats();
      n_deser = 0; n_par = 0; n_strt = 0; n_stop = 0; n_dv = 0; n_fe = 0;
      n_start = 0; dv_cyc = -1; fe_cyc = -1; fall_cyc = -1;
      for (int i = 0; i < 4; i++) begin
         starts[i] = -1;
         start_edges[i] = -1;
      end
      word = 8'h00;
      deser_mask = 16'h0000;
   endtask

   // One clock: observe at the falling edge, then after the rising edge
   // present the registered checker answers and the delayed line sample.
   task automatic tick();
      logic s_en, p_en, t_en;
      @(negedge clk);
      if (bus.deser_en) begin
         n_deser++;
         word = {bus.sampled_bit, word[7:1]};
         deser_mask[bus.bit_cnt] = 1'b1;
      end
      if (bus.par_chk_en)  n_par++;
      if (bus.strt_chk_en) n_strt++;
      if (bus.stop_chk_en) n_stop++;
      if (bus.data_valid) begin n_dv++; dv_cyc = cyc; end
      if (bus.frame_err)  begin n_fe++; fe_cyc = cyc; end
      if (bus.dat_samp_en && !samp_prev) begin
         if (n_start < 4) begin
            starts[n_start]      = cyc;
            start_edges[n_start] = int'(bus.edge_cnt);
         end
         n_start++;
      end
      if (!bus.dat_samp_en && samp_prev) fall_cyc = cyc;
      samp_prev = bus.dat_samp_en;
      s_en = bus.strt_chk_en;
      p_en = bus.par_chk_en;
      t_en = bus.stop_chk_en;
      @(posedge clk);
      #1;
      cyc++;
      bus.strt_glitch = s_en & glitch_cfg;
      bus.par_err     = (p_en & par_cfg) | par_force;
      bus.stop_err    = t_en & stop_cfg;
      rx_p2 = rx_p1;
      rx_p1 = bus.rx_in;
      bus.sampled_bit = rx_p2;
   endtask

   task automatic idle(input int n);
      bus.rx_in = 1'b1;
      repeat (n) tick();
   endtask

   // Start bit, DATA LSB first, optional even parity, stop bit; stops
   // early after max_ticks clocks when max_ticks > 0.
   task automatic send_frame(input int p, input logic [7:0] d, input bit with_par,
                             input int max_ticks);
      logic [10:0] bits;
      int nb;
      int n;
      bits = 11'h7FF;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (with_par) bits[9] = ^d;
      nb = with_par ? 11 : 10;
      n = 0;
      for (int b = 0; b < nb; b++) begin
         for (int e = 0; e < p; e++) begin
            if (max_ticks > 0 && n >= max_ticks) return;
            if (b == 0 && e == 0) low_cyc = cyc;
            bus.rx_in = bits[b];
            tick();
            n++;
         end
      end
      bus.rx_in = 1'b1;
   endtask

   initial begin
      checks = 0; fails = 0; cyc = 0; low_cyc = -1;
      samp_prev = 1'b0; rx_p1 = 1'b1; rx_p2 = 1'b1;
      glitch_cfg = 1'b0; par_cfg = 1'b0; stop_cfg = 1'b0; par_force = 1'b0;
      rst_n = 1'b0;
      bus.rx_in = 1'b1;
      bus.prescale = 6'd8;
      bus.par_en = 1'b0;
      bus.sampled_bit = 1'b1;
      bus.strt_glitch = 1'b0;
      bus.par_err = 1'b0;
      bus.stop_err = 1'b0;
      clear_stats();

      #1;
      check("reset_outs", outs(), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      idle(4);
      check("idle_outs", outs(), 0);

      // prescale 8, no parity, 0x5A, good stop
      clear_stats();
      send_frame(8, 8'h5A, 1'b0, 0);
      idle(20);
      check("p8_start_latency", starts[0] - low_cyc, 1);
      check("p8_start_edge", start_edges[0], 0);
      check("p8_deser_cnt", n_deser, 8);
      check("p8_deser_bits", int'(deser_mask), 16'h00FF);
      check("p8_word", int'(word), 8'h5A);
      check("p8_strt_cnt", n_strt, 1);
      check("p8_stop_cnt", n_stop, 1);
      check("p8_par_cnt", n_par, 0);
      check("p8_dv_cnt", n_dv, 1);
      check("p8_fe_cnt", n_fe, 0);
      check("p8_dv_latency", dv_cyc - starts[0], 79);

      // start glitch: line low for two clocks only
      clear_stats();
      glitch_cfg = 1'b1;
      bus.rx_in = 1'b0;
      tick();
      tick();
      idle(20);
      glitch_cfg = 1'b0;
      check("glitch_strt_cnt", n_strt, 1);
      check("glitch_abort_cyc", fall_cyc - starts[0], 8);
      check("glitch_deser_cnt", n_deser, 0);
      check("glitch_pulses", n_dv + n_fe, 0);
      check("glitch_idle_outs", outs(), 0);

      // stop error, then a frame starting right after the stop bit
      clear_stats();
      stop_cfg = 1'b1;
      send_frame(8, 8'hC3, 1'b0, 0);
      stop_cfg = 1'b0;
      send_frame(8, 8'h96, 1'b0, 0);
      idle(20);
      check("stoperr_fe_cnt", n_fe, 1);
      check("stoperr_fe_latency", fe_cyc - starts[0], 79);
      check("b2b_restart", starts[1] - starts[0], 81);
      check("b2b_dv_cnt", n_dv, 1);
      check("b2b_dv_latency", dv_cyc - starts[1], 79);
      check("b2b_word", int'(word), 8'h96);

      // prescale 32, no parity
      bus.prescale = 6'd32;
      clear_stats();
      send_frame(32, 8'h81, 1'b0, 0);
      idle(20);
      check("p32_dv_latency", dv_cyc - starts[0], 307);
      check("p32_word", int'(word), 8'h81);
      check("p32_fe_cnt", n_fe, 0);

      // prescale 16 with parity requested
      bus.prescale = 6'd16;
      bus.par_en = 1'b1;
`ifdef UART_RX_PARITY_EN
      clear_stats();
      send_frame(16, 8'hA5, 1'b1, 0);
      idle(20);
      check("par_ok_par_cnt", n_par, 1);
      check("par_ok_dv_cnt", n_dv, 1);
      check("par_ok_dv_latency", dv_cyc - starts[0], 171);
      check("par_ok_fe_cnt", n_fe, 0);
      check("par_ok_word", int'(word), 8'hA5);

      clear_stats();
      par_cfg = 1'b1;
      send_frame(16, 8'hA5, 1'b1, 0);
      idle(20);
      par_cfg = 1'b0;
      check("par_err_fe_cnt", n_fe, 1);
      check("par_err_fe_latency", fe_cyc - starts[0], 171);
      check("par_err_dv_cnt", n_dv, 0);

      // parity flag must not leak into the next frame
      clear_stats();
      send_frame(16, 8'h3C, 1'b1, 0);
      idle(20);
      check("par_clear_dv_cnt", n_dv, 1);
      check("par_clear_fe_cnt", n_fe, 0);
`else
      clear_stats();
      par_force = 1'b1;
      send_frame(16, 8'hA5, 1'b0, 0);
      idle(20);
      par_force = 1'b0;
      check("nopar_par_cnt", n_par, 0);
      check("nopar_dv_cnt", n_dv, 1);
      check("nopar_dv_latency", dv_cyc - starts[0], 155);
      check("nopar_fe_cnt", n_fe, 0);
      check("nopar_word", int'(word), 8'hA5);
`endif
      bus.par_en = 1'b0;
      bus.prescale = 6'd8;
      idle(4);

      // reset asserted during DATA bit 4
      clear_stats();
      send_frame(8, 8'hE7, 1'b0, 44);
      check("rst_pre_bit_cnt", int'(bus.bit_cnt), 4);
      check("rst_pre_edge_cnt", int'(bus.edge_cnt), 3);
      rst_n = 1'b0;
      #1;
      check("rst_async_outs", outs(), 0);
      bus.rx_in = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      clear_stats();
      idle(5);
      check("rst_after_starts", n_start, 0);
      check("rst_after_outs", outs(), 0);
      send_frame(8, 8'h3C, 1'b0, 0);
      idle(20);
      check("rst_fresh_dv_cnt", n_dv, 1);
      check("rst_fresh_fe_cnt", n_fe, 0);
      check("rst_fresh_dv_latency", dv_cyc - starts[0], 79);
      check("rst_fresh_word", int'(word), 8'h3C);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
